transmitter: RTL and testbench



---
 rtl/transceiver_pkg.sv | 21 ++
 rtl/transmitter_bit_timer.sv | 34 +++
 rtl/transmitter.sv | 124 ++++++++++++
 tb/tb_transmitter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/transceiver_pkg.sv
// Shared serial-link definitions: TX state encoding, line levels and the odd-parity helper
// used by the transmitter, receiver and parity decoder.
package transceiver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Callers zero-extend narrower words; the extra zeros do not change the parity.
  function automatic logic odd_parity(input logic [63:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/transmitter_bit_timer.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. tick marks the terminal count;
// clear forces the count back to 0.
module transmitter_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// Serial frame transmitter: start bit, DATA_WIDTH data bits LSB-first, odd parity, stop bit(s).
// Define TX_TWO_STOP_EN to send two stop bits instead of one.
module transmitter
  import transceiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] in_byte,
  input  logic                  valid,
  output logic                  ready,
  output logic                  out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IdxW-1:0]       idx_q;
  logic                  parity_q;
  logic                  out_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  tick;
  logic                  timer_clear;
  logic                  stop_last;

  // Holding the timer clear while idle means every state entry starts from count 0.
  assign timer_clear = (state_q == StIdle);

  transmitter_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .arst (arst),
    .clear(timer_clear),
    .tick (tick)
  );

`ifdef TX_TWO_STOP_EN
  logic stop2_q;
  assign stop_last = stop2_q;
`else
  assign stop_last = 1'b1;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      out_q    <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef TX_TWO_STOP_EN
      stop2_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            shift_q  <= in_byte;
            parity_q <= odd_parity(64'(in_byte));
            out_q    <= START_LEVEL;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            idx_q   <= '0;
            out_q   <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (idx_q == LastIdx) begin
              out_q   <= parity_q;
              state_q <= StParity;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + IdxW'(1);
              out_q   <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (tick) begin
            out_q   <= IDLE_LEVEL;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (tick && stop_last) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`ifdef TX_TWO_STOP_EN
          // Toggles 0->1 after the first stop bit and back to 0 as the frame ends.
          if (tick) begin
            stop2_q <= ~stop2_q;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = (state_q == StStop) && tick && stop_last;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: two instances (1 and 4 clocks per bit) checked every cycle against a
// frame-position model, plus directed literal checks.
module tb_transmitter;

`ifdef TX_TWO_STOP_EN
  localparam int NSTOP     = 2;
  localparam int DONE_K    = 12;
  localparam int READY_K   = 13;
  localparam int SPACING_B = 49;
`else
  localparam int NSTOP     = 1;
  localparam int DONE_K    = 11;
  localparam int READY_K   = 12;
  localparam int SPACING_B = 45;
`endif

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] in_byte_a, in_byte_b;
  logic       valid_a, valid_b;
  logic       ready_a, out_a, busy_a, done_a;
  logic       ready_b, out_b, busy_b, done_b;

  transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut_a (
    .clk(clk), .arst(arst), .in_byte(in_byte_a), .valid(valid_a),
    .ready(ready_a), .out(out_a), .busy(busy_a), .done(done_a)
  );

  transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut_b (
    .clk(clk), .arst(arst), .in_byte(in_byte_b), .valid(valid_b),
    .ready(ready_b), .out(out_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int n_check = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic       va_s = 1'b0, vb_s = 1'b0;
  logic [7:0] ba_s = 8'h00, bb_s = 8'h00;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    va_s <= valid_a && !arst;
    vb_s <= valid_b && !arst;
    ba_s <= in_byte_a;
    bb_s <= in_byte_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int frame_len(input int c);
    return (10 + NSTOP) * c;
  endfunction

  // Expected {out, busy, ready, done} at position p (1..F) of a frame; p == 0 is idle.
  function automatic logic [3:0] expect_at(input logic [7:0] b, input int p, input int c);
    int   j;
    logic ln;
    if (p == 0) return 4'b1010;
    j = (p - 1) / c;
    if (j == 0) ln = 1'b0;
    else if (j <= 8) ln = b[j-1];
    else if (j == 9) ln = ~^b;
    else ln = 1'b1;
    return {ln, 1'b1, 1'b0, p == frame_len(c)};
  endfunction

  int         pos_a = 0, pos_b = 0;
  logic [7:0] mb_a = 8'h00, mb_b = 8'h00;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (arst) begin
        pos_a = 0;
        pos_b = 0;
      end else begin
        if (pos_a == 0) begin
          if (va_s) begin pos_a = 1; mb_a = ba_s; end
        end else if (pos_a == frame_len(1)) pos_a = 0;
        else pos_a++;
        if (pos_b == 0) begin
          if (vb_s) begin pos_b = 1; mb_b = bb_s; end
        end else if (pos_b == frame_len(4)) pos_b = 0;
        else pos_b++;
      end
      chk("a_cycle", {out_a, busy_a, ready_a, done_a}, expect_at(mb_a, pos_a, 1));
      chk("b_cycle", {out_b, busy_b, ready_b, done_b}, expect_at(mb_b, pos_b, 4));
    end
  end

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    valid_a   = 1'b1;
    in_byte_a = b;
    @(posedge clk);
    #1;
    valid_a   = 1'b0;
    in_byte_a = ~b;
  endtask

  // k = 1 is the cycle right after the accepting edge.
  task automatic capture_a(output logic [15:0] seq, output int done_at, output int ready_at);
    seq      = '0;
    done_at  = -1;
    ready_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 16) seq[k-1] = out_a;
      if (done_a && done_at < 0) done_at = k;
      if (ready_a) begin
        ready_at = k;
        break;
      end
    end
  endtask

  logic [15:0] seq;
  logic [43:0] vb;
  int          d_at, r_at, a1, a2;
  logic        seen, got;

  initial begin
    valid_a = 1'b0; valid_b = 1'b0;
    in_byte_a = 8'h00; in_byte_b = 8'h00;
    repeat (3) @(negedge clk);
    #1 arst = 1'b0;

    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | done_a | done_b;
    end
    chk("idle_out", out_a, 1);
    chk("idle_ready", ready_a, 1);
    chk("idle_busy", busy_a, 0);
    chk("idle_done_seen", seen, 0);

    send_a(8'h5A);
    capture_a(seq, d_at, r_at);
    chk("5a_line", seq[10:0], 11'b11010110100);
    chk("5a_done_at", d_at, DONE_K);
    chk("5a_ready_at", r_at, READY_K);

    send_a(8'h00); capture_a(seq, d_at, r_at);
    chk("parity_00", seq[9], 1);
    send_a(8'hFF); capture_a(seq, d_at, r_at);
    chk("parity_ff", seq[9], 1);
    send_a(8'h07); capture_a(seq, d_at, r_at);
    chk("parity_07", seq[9], 0);

    // Four clocks per bit, valid held high across two frames.
    @(negedge clk);
    in_byte_b = 8'h81;
    valid_b   = 1'b1;
    @(posedge clk);
    #1 a1 = cyc;
    in_byte_b = 8'h3C;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      vb[k] = out_b;
    end
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready_b) begin got = 1'b1; break; end
    end
    @(posedge clk);
    #1 a2 = cyc;
    valid_b   = 1'b0;
    in_byte_b = 8'h00;
    chk("b_ready_return", got, 1);
    chk("b_81_line", vb, 44'hFFF000000F0);
    chk("b_accept_spacing", a2 - a1, SPACING_B);
    got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ready_b) begin got = 1'b1; break; end
    end
    chk("b_second_frame_end", got, 1);

    // Abort 0xA5 during data bit 3, then send 0x3C cleanly.
    send_a(8'hA5);
    repeat (4) @(posedge clk);
    #1 chk("rst_pre_bit3", out_a, 0);
    arst = 1'b1;
    #1;
    chk("rst_out_async", out_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_done", done_a, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done_a;
    end
    #1 arst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | done_a;
    end
    chk("rst_no_done", seen, 0);
    chk("rst_ready_after", ready_a, 1);
    send_a(8'h3C);
    capture_a(seq, d_at, r_at);
    chk("3c_line", seq[10:0], 11'b11001111000);
    chk("3c_done_at", d_at, DONE_K);
    chk("3c_ready_at", r_at, READY_K);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
